// File: rtl/pab_ram_slave.sv
// pab_ram_slave: PAB bus target backed by an on-chip word-addressed RAM with a
// programmable wait-state delay. Define PAB_RAM_BOUNDS_EN for out-of-window detection.
module pab_ram_slave #(
    parameter int          MEM_WORDS   = 1024,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [31:0] PAB_ADDR,
    input  logic        PAB_RD,
    input  logic        PAB_WR,
    input  logic        PAB_VALID,
    input  logic [31:0] PAB_DATA,
    input  logic [3:0]  PAB_BE,
    output logic        MEM_READY,
    output logic        MEM_VALID,
    output logic [31:0] MEM_DATA,
    output logic        MEM_ERR
);
    localparam int         IDX_W = $clog2(MEM_WORDS);
    localparam logic [7:0] WS_L  = 8'(WAIT_STATES);

    // ST_WAIT covers WAIT_STATES delay cycles plus the final RAM access cycle.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESP    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_rd;
    logic             r_wr;
    logic             r_oow;
    logic [31:0]      r_wdata;
    logic [3:0]       r_be;
    logic             r_ready;
    logic             r_valid;
    logic             r_err;
    logic [31:0]      r_rdata;
    logic [31:0]      r_mem [MEM_WORDS];

    logic             w_oow;
    logic             w_unused_addr;
    logic             w_access;
    logic             w_commit;

`ifdef PAB_RAM_BOUNDS_EN
    assign w_oow         = |PAB_ADDR[31:IDX_W+2];
    assign w_unused_addr = ^PAB_ADDR[1:0];
`else
    // Upper address bits alias onto the RAM; byte offset is never used.
    assign w_oow         = 1'b0;
    assign w_unused_addr = ^{PAB_ADDR[31:IDX_W+2], PAB_ADDR[1:0]};
`endif

    assign w_access = (r_state == ST_WAIT) && (r_cnt == WS_L);
    assign w_commit = w_access && r_wr && !r_oow;

    assign MEM_READY = r_ready;
    assign MEM_VALID = r_valid;
    assign MEM_DATA  = r_rdata;
    assign MEM_ERR   = r_err;

    // Handshake FSM, request capture and registered response outputs.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_idx   <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_oow   <= 1'b0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (PAB_VALID) begin
                        r_idx   <= PAB_ADDR[IDX_W+1:2];
                        r_rd    <= PAB_RD;
                        r_wr    <= PAB_WR;
                        r_oow   <= w_oow;
                        r_wdata <= PAB_DATA;
                        r_be    <= PAB_BE;
                        r_cnt   <= 8'd0;
                        r_ready <= 1'b0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_access) begin
                        // Read sees the pre-write word because the RAM updates on this same edge.
                        r_rdata <= r_rd ? (r_oow ? ERR_DATA : r_mem[r_idx]) : 32'd0;
                        r_err   <= r_err | r_oow;
                        r_valid <= 1'b1;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    r_valid <= 1'b0;
                    r_state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!PAB_VALID) begin
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Byte-lane write port; contents are intentionally not reset.
    always_ff @(posedge CLK) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_pab_ram_slave.sv
// Scoreboard bench for pab_ram_slave: one instance with two wait states, one with none.
module tb_pab_ram_slave;
    localparam int WS0 = 2;
    localparam int WS1 = 0;

    typedef struct {
        int          d;
        int          cyc;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_vld  [2];
    logic        i_rd   [2];
    logic        i_wr   [2];
    logic [31:0] i_addr [2];
    logic [31:0] i_wdat [2];
    logic [3:0]  i_be   [2];
    wire  [1:0]  o_rdy;
    wire  [1:0]  o_vld;
    wire  [1:0]  o_err;
    wire  [31:0] o_dat0;
    wire  [31:0] o_dat1;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb_q [$];
    exp_t mon_e;
    logic [31:0] ref_mem [int];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pab_ram_slave #(.MEM_WORDS(1024), .WAIT_STATES(WS0), .ERR_DATA(32'hDEADBEEF)) u_dut0 (
        .CLK(clk), .RES(rst), .PAB_ADDR(i_addr[0]), .PAB_RD(i_rd[0]), .PAB_WR(i_wr[0]),
        .PAB_VALID(i_vld[0]), .PAB_DATA(i_wdat[0]), .PAB_BE(i_be[0]),
        .MEM_READY(o_rdy[0]), .MEM_VALID(o_vld[0]), .MEM_DATA(o_dat0), .MEM_ERR(o_err[0])
    );

    pab_ram_slave #(.MEM_WORDS(1024), .WAIT_STATES(WS1), .ERR_DATA(32'hDEADBEEF)) u_dut1 (
        .CLK(clk), .RES(rst), .PAB_ADDR(i_addr[1]), .PAB_RD(i_rd[1]), .PAB_WR(i_wr[1]),
        .PAB_VALID(i_vld[1]), .PAB_DATA(i_wdat[1]), .PAB_BE(i_be[1]),
        .MEM_READY(o_rdy[1]), .MEM_VALID(o_vld[1]), .MEM_DATA(o_dat1), .MEM_ERR(o_err[1])
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] dat(input int d);
        return (d == 0) ? o_dat0 : o_dat1;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    task automatic drive(input int d, input logic v, input logic [31:0] a, input logic r,
                         input logic w, input logic [31:0] wd, input logic [3:0] b);
        i_vld[d]  = v;
        i_addr[d] = a;
        i_rd[d]   = r;
        i_wr[d]   = w;
        i_wdat[d] = wd;
        i_be[d]   = b;
    endtask

    task automatic wait_ready(input int d);
        int n;
        n = 0;
        @(negedge clk);
        while (!o_rdy[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(o_rdy[d]), 32'd1);
    endtask

    // One complete transaction; request fields are scrambled after accept.
    task automatic txn(input int d, input logic [31:0] a, input logic r, input logic w,
                       input logic [31:0] wd, input logic [3:0] b, input logic [31:0] ed,
                       input int hold);
        exp_t e;
        int   n;
        wait_ready(d);
        drive(d, 1'b1, a, r, w, wd, b);
        @(posedge clk);
        #1;
        e.d    = d;
        e.cyc  = cyc + 1 + ((d == 0) ? WS0 : WS1);
        e.chk  = r | ~w;
        e.data = ed;
        sb_q.push_back(e);
        drive(d, 1'b1, a ^ 32'h0000_0FF0, ~r, ~w, ~wd, ~b);
        n = 0;
        while (!o_vld[d] && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("valid_wait", 32'(o_vld[d]), 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("ready_hold", 32'(o_rdy[d]), 32'd0);
        end
        drive(d, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0);
    endtask

    task automatic chk_reset_vals(input int d);
        chk("rst_ready", 32'(o_rdy[d]), 32'd1);
        chk("rst_valid", 32'(o_vld[d]), 32'd0);
        chk("rst_data", dat(d), 32'd0);
        chk("rst_err", 32'(o_err[d]), 32'd0);
    endtask

    // Response monitor: every MEM_VALID pops one expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (o_vld[d] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid", 32'(d), 32'hFFFF_FFFF);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("rsp_port", 32'(d), 32'(mon_e.d));
                    chk("rsp_latency", 32'(cyc), 32'(mon_e.cyc));
                    if (mon_e.chk) chk("rsp_data", dat(d), mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        int          idx;
        drive(0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0);
        drive(1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_vals(0);
        chk_reset_vals(1);

        // Committed write survives a reset; a write caught in WAIT does not.
        txn(0, 32'h20, 1'b0, 1'b1, 32'h12345678, 4'hF, 32'd0, 0);
        txn(0, 32'h20, 1'b1, 1'b0, 32'd0, 4'hF, 32'h12345678, 0);
        wait_ready(0);
        drive(0, 1'b1, 32'h20, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals(0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0);
        rst = 1'b0;
        txn(0, 32'h20, 1'b1, 1'b0, 32'd0, 4'hF, 32'h12345678, 0);

        // Full, partial and empty byte-enable writes.
        txn(0, 32'h10, 1'b0, 1'b1, 32'h11223344, 4'hF, 32'd0, 0);
        txn(0, 32'h10, 1'b1, 1'b0, 32'd0, 4'hF, 32'h11223344, 0);
        txn(0, 32'h10, 1'b0, 1'b1, 32'hAABBCCDD, 4'b0101, 32'd0, 0);
        txn(0, 32'h10, 1'b1, 1'b0, 32'd0, 4'hF, 32'h11BB33DD, 0);
        txn(0, 32'h10, 1'b0, 1'b1, 32'h99999999, 4'b0000, 32'd0, 0);
        txn(0, 32'h10, 1'b1, 1'b0, 32'd0, 4'b0000, 32'h11BB33DD, 3);

        // Read+write returns the old word; no-op request returns zero.
        txn(0, 32'h10, 1'b1, 1'b1, 32'h01020304, 4'hF, 32'h11BB33DD, 0);
        txn(0, 32'h10, 1'b1, 1'b0, 32'd0, 4'hF, 32'h01020304, 0);
        txn(0, 32'h10, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'hF, 32'd0, 1);

        txn(0, 32'h1010, 1'b0, 1'b1, 32'h5A5A5A5A, 4'hF, 32'd0, 0);
`ifdef PAB_RAM_BOUNDS_EN
        txn(0, 32'h1010, 1'b1, 1'b0, 32'd0, 4'hF, 32'hDEADBEEF, 0);
        txn(0, 32'h0010, 1'b1, 1'b0, 32'd0, 4'hF, 32'h01020304, 0);
        @(negedge clk);
        chk("err_sticky", 32'(o_err[0]), 32'd1);
`else
        txn(0, 32'h0010, 1'b1, 1'b0, 32'd0, 4'hF, 32'h5A5A5A5A, 0);
        txn(0, 32'h1013, 1'b1, 1'b0, 32'd0, 4'hF, 32'h5A5A5A5A, 0);
        @(negedge clk);
        chk("err_tied", 32'(o_err[0]), 32'd0);
`endif

        // Zero wait states, then two cores interleaving through the same port.
        txn(1, 32'h30, 1'b0, 1'b1, 32'hCAFEF00D, 4'hF, 32'd0, 0);
        txn(1, 32'h30, 1'b1, 1'b0, 32'd0, 4'hF, 32'hCAFEF00D, 0);
        for (int i = 0; i < 8; i++) begin
            a   = ((i % 4) == 0 || (i % 4) == 3) ? 32'h80 : 32'h84;
            idx = int'(a[11:2]);
            if ((i % 4) < 2) begin
                wd = (((i % 2) == 0) ? 32'hA000_0000 : 32'hB000_0000) | 32'(i * 32'h0101_0101);
                be = (i < 4) ? 4'hF : (((i % 2) == 0) ? 4'b1100 : 4'b0011);
                ref_mem[idx] = (i < 4) ? wd : merge(ref_mem[idx], wd, be);
                txn(1, a, 1'b0, 1'b1, wd, be, 32'd0, 0);
            end else begin
                txn(1, a, 1'b1, 1'b0, 32'd0, 4'hF, ref_mem[idx], 0);
            end
        end

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pab_ram_slave.md
Name: pab_ram_slave

Overview:
- Downstream target of the multi-core PAB memory arbiter: consumes the PAB request bus (address, RD/WR, data, byte enables, VALID) and returns MEM_READY, MEM_VALID and MEM_DATA.
- Backs requests with an on-chip word-addressed RAM.
- Inserts a programmable number of wait states to emulate slower memory.
- Serves one transaction at a time and requires PAB_VALID to drop between transactions.

Parameters:
- MEM_WORDS, 1024: RAM depth in 32-bit words; power of two, minimum 4.
- WAIT_STATES, 2: extra cycles between accept and response; 0..255.
- ERR_DATA, 32'hDEADBEEF: read data returned for out-of-window reads (optional feature only).

Ports:
- CLK  in  1  clock, rising edge.
- RES  in  1  reset, asynchronous, active-high.
- PAB_ADDR  in  32  byte address; word index = PAB_ADDR[log2(MEM_WORDS)+1:2].
- PAB_RD  in  1  read request.
- PAB_WR  in  1  write request.
- PAB_VALID  in  1  request valid; held by the master until it sees MEM_VALID.
- PAB_DATA  in  32  write data.
- PAB_BE  in  4  byte enables; bit n = byte lane n = DATA[8n+7:8n].
- MEM_READY  out  1  slave idle and able to accept.
- MEM_VALID  out  1  one-cycle response strobe.
- MEM_DATA  out  32  read data, valid while MEM_VALID=1, held afterwards.
- MEM_ERR  out  1  sticky out-of-window flag; constant 0 without the optional feature.

Behaviour:
- Reset values: MEM_READY=1, MEM_VALID=0, MEM_DATA=0, MEM_ERR=0, state=IDLE, wait counter=0.
- RAM contents are not reset.
- States:
  - IDLE: MEM_READY=1. On an edge with PAB_VALID=1, latch ADDR/RD/WR/DATA/BE and deassert MEM_READY. Go to WAIT if WAIT_STATES>0, otherwise RESP.
  - WAIT: count WAIT_STATES cycles, then go to RESP. Bus inputs are ignored in this state.
  - RESP: MEM_VALID=1 for exactly one cycle. Go to RELEASE.
  - RELEASE: MEM_READY=0. Go to IDLE on the first edge with PAB_VALID=0; otherwise stay.
- Latency: accept edge at cycle N gives MEM_VALID high during cycle N+1+WAIT_STATES.
- With the arbiter (VALID dropped the cycle after MEM_VALID), the next accept is possible at the earliest 2 cycles after MEM_VALID.
- Write commit: performed at the edge entering RESP, using only lanes with BE=1; other bytes are unchanged.
- BE=0000 write: no RAM change, but still responds.
- Read: MEM_DATA is registered from the RAM word at the edge entering RESP (full word; BE ignored).
- RD=1 and WR=1: write is performed; MEM_DATA returns the pre-write word.
- RD=0 and WR=0 with VALID=1: no RAM access; MEM_VALID still pulses; MEM_DATA=0.
- Address wrap: bits above the index field and bits [1:0] are ignored; addresses alias modulo 4*MEM_WORDS.
- Request fields that change after accept have no effect on the current transaction.
- Reset mid-transaction: immediately returns all outputs to reset values. A write not yet committed is discarded; an already-committed write remains.

Optional Feature:
- Macro: PAB_RAM_BOUNDS_EN.
- When defined:
  - Any of PAB_ADDR[31:log2(MEM_WORDS)+2] nonzero at accept marks the transaction out-of-window.
  - Out-of-window writes are suppressed.
  - Out-of-window reads return ERR_DATA.
  - MEM_ERR is set at the RESP edge and held until RES.
  - Handshake timing is unchanged.
- When undefined: addresses alias as described above and MEM_ERR is tied to 0.

Test Plan:
- Reset release -> MEM_READY=1, MEM_VALID=0, MEM_DATA=0, MEM_ERR=0; assert RES mid-WAIT -> same values next cycle, pending write absent on readback.
- WAIT_STATES=2: write 0x11223344 to 0x10 with BE=1111, accepted at cycle N -> MEM_VALID high only at N+3; then read 0x10 -> MEM_DATA=0x11223344.
- Partial write 0xAABBCCDD to 0x10 with BE=0101 over 0x11223344 -> readback 0x11BB33DD; BE=0000 write -> word unchanged, MEM_VALID still pulses.
- Hold PAB_VALID high 3 cycles after MEM_VALID -> no second MEM_VALID, MEM_READY stays 0 until VALID drops; WAIT_STATES=0 -> MEM_VALID the cycle after accept.
- MEM_WORDS=1024: write 0x5A5A5A5A to 0x1010 -> without the macro, read 0x0010 returns 0x5A5A5A5A; with PAB_RAM_BOUNDS_EN, the write is dropped, the read of 0x1010 returns 0xDEADBEEF, and MEM_ERR=1 stays set.
- Two-core arbiter plus this block, both cores issuing alternating reads and writes -> every core request gets exactly one MEM_VALID, and the data matches a reference RAM model.
